// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in/serial-out bit serializer.
// State encoding is fixed here so that the serializer and any block
// observing its state agree on the values.
package piso_pkg;

    // Default word width of the serializer.
    localparam int WIDTH_DEFAULT = 8;

    // State encoding.
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_SHIFT  = SHIFT,
        ST_PARITY = PARITY
    } state_t;

endpackage

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out bit serializer.
// Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit
// per clock on sout with sout_valid. A new word may be accepted in the cycle
// that presents the final serial bit, so consecutive words stream without a gap.
// Optional feature macro: PISO_SER_PARITY_EN appends an even-parity bit after
// the data bits (word period WIDTH+1 instead of WIDTH).
module piso_bit_serializer
    import piso_pkg::*;
#(
    parameter int   WIDTH     = WIDTH_DEFAULT,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic             r_sout;
    logic             w_sout_next;
    logic             r_sout_valid;
    logic             w_sout_valid_next;

`ifdef PISO_SER_PARITY_EN
    logic             r_parity;
    logic             w_parity_next;
`endif

    logic             w_accept;
    logic             w_final;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_load_shift;
    logic [WIDTH-1:0] w_adv_shift;

    // Bit-order selection: the shift register always holds the bits still to
    // be sent, aligned so the next one sits at the outgoing end.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_first_bit  = din[WIDTH-1];
            assign w_load_shift = din << 1;
            assign w_next_bit   = r_shift[WIDTH-1];
            assign w_adv_shift  = r_shift << 1;
        end else begin : g_lsb_first
            assign w_first_bit  = din[0];
            assign w_load_shift = din >> 1;
            assign w_next_bit   = r_shift[0];
            assign w_adv_shift  = r_shift >> 1;
        end
    endgenerate

    // The cycle presenting the last serial bit of a word.
`ifdef PISO_SER_PARITY_EN
    assign w_final = (r_state == ST_PARITY);
`else
    assign w_final = (r_state == ST_SHIFT) && (r_count == '0);
`endif

    // Ready in IDLE or on the final bit; held low while reset is asserted.
    assign din_ready = rst && ((r_state == ST_IDLE) || w_final);
    assign w_accept  = din_valid && din_ready;

    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign busy       = (r_state != ST_IDLE);
    assign word_done  = w_final;

    // Next-state and datapath decode. din_ready is only high in IDLE or on
    // the final bit, so an accept can only occur in those cycles; the load
    // at the bottom therefore overrides exactly those branches.
    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_shift_next      = r_shift;
        w_sout_next       = IDLE_BIT;
        w_sout_valid_next = 1'b0;
`ifdef PISO_SER_PARITY_EN
        w_parity_next     = r_parity;
`endif

        case (r_state)
            ST_IDLE: begin
                w_state_next = ST_IDLE;
            end
            ST_SHIFT: begin
                if (r_count != '0) begin
                    w_sout_next       = w_next_bit;
                    w_sout_valid_next = 1'b1;
                    w_shift_next      = w_adv_shift;
                    w_count_next      = r_count - CNT_ONE;
                end else begin
`ifdef PISO_SER_PARITY_EN
                    w_state_next      = ST_PARITY;
                    w_sout_next       = r_parity;
                    w_sout_valid_next = 1'b1;
`else
                    w_state_next      = ST_IDLE;
`endif
                end
            end
`ifdef PISO_SER_PARITY_EN
            ST_PARITY: begin
                w_state_next = ST_IDLE;
            end
`endif
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_accept) begin
            w_state_next      = ST_SHIFT;
            w_count_next      = CNT_LOAD;
            w_shift_next      = w_load_shift;
            w_sout_next       = w_first_bit;
            w_sout_valid_next = 1'b1;
`ifdef PISO_SER_PARITY_EN
            w_parity_next     = ^din;
`endif
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath registers: counter, shift register and registered serial outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count      <= '0;
            r_shift      <= '0;
            r_sout       <= IDLE_BIT;
            r_sout_valid <= 1'b0;
        end else begin
            r_count      <= w_count_next;
            r_shift      <= w_shift_next;
            r_sout       <= w_sout_next;
            r_sout_valid <= w_sout_valid_next;
        end
    end

`ifdef PISO_SER_PARITY_EN
    // Parity of the word in flight, captured when the word is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity <= 1'b0;
        end else begin
            r_parity <= w_parity_next;
        end
    end
`endif

endmodule
